// File: rtl/prog_pkg.sv
// Shared constants and types for the serial program loader.
package prog_pkg;

  localparam int unsigned WORD_W     = 5;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned FRAME_BITS = 6;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned WCNT_W     = 5;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Even parity holds when the XOR over the data word and its parity bit is zero.
  function automatic logic even_parity_ok(input logic [WORD_W-1:0] word, input logic pbit);
    return (^{word, pbit}) == 1'b0;
  endfunction

endpackage

// File: rtl/prog_loader_ser_if.sv
// Handshake/bus bundle between the program source/CPU side and the loader.
interface prog_loader_ser_if;
  import prog_pkg::*;

  logic              ser_in;
  logic              ser_valid;
  logic              run;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] instruction;
  logic              master_clear;
  logic [WCNT_W-1:0] word_count;
  logic              par_err;
  logic              ovf;

  modport master (
    output ser_in, ser_valid, run, address,
    input  instruction, master_clear, word_count, par_err, ovf
  );

  modport slave (
    input  ser_in, ser_valid, run, address,
    output instruction, master_clear, word_count, par_err, ovf
  );

endinterface

// File: rtl/prog_mem_16x5.sv
// 16x5 program store: synchronous write, asynchronous read, synchronous clear-to-zero.
module prog_mem_16x5
  import prog_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader_ser.sv
// Serial program loader: deserialises parity-protected frames into program
// memory while holding the CPU in reset, then releases it on run.
module prog_loader_ser
  import prog_pkg::*;
(
  input  logic clk,
  input  logic clear,
  prog_loader_ser_if.slave bus
);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [WCNT_W-1:0] FULL_CNT = WCNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WCNT_W-1:0] word_count_q, word_count_d;
  logic              par_err_q, par_err_d;
  logic              ovf_q, ovf_d;
  logic              master_clear_q;

  logic              mem_we;
  logic              frame_done;
  logic              parity_ok;
  logic              mem_full;

  assign frame_done = bus.ser_valid && (bit_cnt_q == LAST_BIT);
  assign parity_ok  = even_parity_ok(shift_q, bus.ser_in);
  assign mem_full   = (word_count_q == FULL_CNT);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q        <= LOAD;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      word_count_q   <= '0;
      par_err_q      <= 1'b0;
      ovf_q          <= 1'b0;
      master_clear_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      word_count_q   <= word_count_d;
      par_err_q      <= par_err_d;
      ovf_q          <= ovf_d;
      // Follows the state one edge late, so the CPU sees one clean release edge.
      master_clear_q <= (state_q == LOAD);
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    par_err_d    = par_err_q;
    ovf_d        = ovf_q;
    mem_we       = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (frame_done) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          if (!parity_ok) begin
            par_err_d = 1'b1;
          end
          if (mem_full) begin
            ovf_d = 1'b1;
          end else if (parity_ok) begin
            mem_we       = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
          end
        end else if (bus.ser_valid) begin
          shift_d   = {shift_q[WORD_W-2:0], bus.ser_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // A frame completing on this edge is committed above before leaving.
        if (bus.run) begin
          state_d   = RUN;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  prog_mem_16x5 u_mem (
    .clk   (clk),
    .clear (clear),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (shift_q),
    .raddr (bus.address),
    .rdata (bus.instruction)
  );

  assign bus.master_clear = master_clear_q;
  assign bus.word_count   = word_count_q;
  assign bus.par_err      = par_err_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: doc/prog_loader_ser.md
PROG_LOADER_SER -- requirements
Module: prog_loader_ser

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports named clk and clear.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  synchronous active-high reset.
REQ-004 ser_in  input  1  serial program bit, MSB first.
REQ-005 ser_valid  input  1  ser_in is sampled on each rising clk edge where ser_valid=1 (one bit per qualified cycle).
REQ-006 run  input  1  level request to leave load mode and release the CPU.
REQ-007 address  input  4  program-counter address from the CPU.
REQ-008 instruction  output  5  program word stored at address.
REQ-009 master_clear  output  1  holds the CPU in reset while loading.
REQ-010 word_count  output  5  number of words committed, 0..16.
REQ-011 par_err  output  1  sticky parity-error flag.
REQ-012 ovf  output  1  sticky overflow flag: a frame arrived with memory full.

Function
REQ-013 Frame is 6 bits: 5 instruction bits (bit4 first), then 1 even-parity bit (XOR of all 6 bits = 0).
REQ-014 FSM states are LOAD and RUN only.
REQ-015 In LOAD, master_clear=1 and each qualified bit shifts into a 5-bit shift register; a 3-bit counter bit_cnt runs 0..5.
REQ-016 On the qualified cycle with bit_cnt=5 and good parity, the word is written to mem[wr_ptr] at that same edge, wr_ptr and word_count increment, and bit_cnt returns to 0.
REQ-017 On the bit_cnt=5 cycle with bad parity, no write occurs, wr_ptr is unchanged, par_err sets to 1, and bit_cnt returns to 0.
REQ-018 When word_count=16, completed frames are not written, ovf sets to 1, and word_count stays 16 (no wrap).
REQ-019 In LOAD with run=1 and bit_cnt=0, the next state is RUN.
REQ-020 In LOAD with run=1 and bit_cnt≠0, the next state is RUN and the partial frame is discarded (bit_cnt to 0, no write).
REQ-021 If the 6th bit and run=1 occur in the same cycle, the frame is committed first (per REQ-016..018) and the state becomes RUN at the same edge.
REQ-022 In RUN, master_clear=0, ser_valid is ignored, and the memory is read-only; the state is left only by clear.
REQ-023 instruction=mem[address], as a combinational read, in both states; unwritten entries read 5'b00000.
REQ-024 master_clear is a registered output: it falls on the first clk edge after entry to RUN, so the CPU sees exactly one deasserting edge.

Reset
REQ-025 clear=1 at a rising edge SHALL force: state=LOAD, master_clear=1, all 16 mem entries=0, shift register=0, bit_cnt=0, wr_ptr=0, word_count=0, par_err=0, ovf=0.
REQ-026 clear SHALL take precedence over ser_valid and run in the same cycle, including mid-frame and in RUN.
REQ-027 No asynchronous reset paths.

Structure
REQ-028 Shared package prog_pkg SHALL hold: WORD_W=5, DEPTH=16, ADDR_W=4, FRAME_BITS=6, and the state enum {LOAD, RUN}.
REQ-029 Storage SHALL be the sub-module prog_mem_16x5: synchronous write port (we, waddr, wdata), asynchronous read port, clear-to-zero.
REQ-030 The FSM, shifter, parity check and counters SHALL reside in prog_loader_ser.

Verification
REQ-031 Load 3 good frames (10110+p=1, 00011+p=0, 11111+p=1), then run=1 -> word_count=3; mem[0..2]=10110,00011,11111; master_clear falls 1 cycle later; address=3 -> instruction=00000.
REQ-032 Frame 10110 sent with parity 0 -> par_err=1; word_count unchanged; the next good frame lands at mem[wr_ptr] unchanged.
REQ-033 Send 17 good frames -> word_count=16, ovf=1, mem[15] holds frame 16, mem[0] unchanged.
REQ-034 run=1 after 3 bits of a frame -> RUN; word_count unchanged; later ser_valid activity does not change memory.
REQ-035 6th bit and run coincide -> word is written and the state is RUN at the same edge.
REQ-036 clear pulsed in RUN and mid-frame -> all outputs match REQ-025 on the next cycle; reload works from wr_ptr=0.
